// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter
// Shares the IO controller's single SD-card block interface between two disk
// clients (0: VHD engine, 1: floppy/config engine). Round-robin grant, host
// handshake sequencing, byte-strobe and write-data routing to the granted
// client only.
//
// Optional feature: define SD_ARB_TIMEOUT_EN to enable the host-ack watchdog.
// With it, a transaction whose sd_ack never rises within TIMEOUT_CYCLES
// clk_ram cycles is aborted and reported through cN_err. Without it, ISSUE
// waits indefinitely and cN_err is constant 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; arbitrate between armed requests
// ISSUE | sd_rd/sd_wr driven, waiting for synchronized sd_ack rise
// XFER  | host acked, byte strobes routed, waiting for sd_ack fall
// DONE  | one-cycle completion pulse to the granted client
module sd_block_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        clk_ram,
    input  logic        reset,
    input  logic [31:0] c0_lba,
    input  logic [31:0] c1_lba,
    input  logic        c0_rd,
    input  logic        c1_rd,
    input  logic        c0_wr,
    input  logic        c1_wr,
    input  logic [7:0]  c0_din,
    input  logic [7:0]  c1_din,
    output logic        c0_ack,
    output logic        c1_ack,
    output logic        c0_done,
    output logic        c1_done,
    output logic        c0_err,
    output logic        c1_err,
    output logic        c0_dout_strobe,
    output logic        c1_dout_strobe,
    output logic        c0_din_strobe,
    output logic        c1_din_strobe,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_dout_strobe,
    input  logic        sd_din_strobe,
    output logic [7:0]  sd_din,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        armed0;
    logic        armed1;

    logic        ack_meta;
    logic        ack_sync;
    logic        ack_prev;
    logic        ack_rise;
    logic        ack_fall;

    logic        req0;
    logic        req1;
    logic        win;
    logic        win_rd;
    logic [31:0] win_lba;
    logic        xfer_phase;

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic        c0_err_q;
    logic        c1_err_q;
`endif

    // sd_ack comes from the host clock domain: two-flop synchronizer plus a
    // delayed copy for edge detection
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
            ack_prev <= 1'b0;
        end else begin
            ack_meta <= sd_ack;
            ack_sync <= ack_meta;
            ack_prev <= ack_sync;
        end
    end

    assign ack_rise = ack_sync & ~ack_prev;
    assign ack_fall = ~ack_sync & ack_prev;

    // Request qualification and round-robin winner selection
    always_comb begin
        req0 = (c0_rd | c0_wr) & armed0;
        req1 = (c1_rd | c1_wr) & armed1;
        if (req0 & req1) begin
            win = ~last_grant;
        end else begin
            win = req1;
        end
        // read wins when a client raises both rd and wr
        win_rd  = win ? c1_rd : c0_rd;
        win_lba = win ? c1_lba : c0_lba;
    end

    // A client is re-armed by any cycle with no request, and disarmed by its
    // done pulse so a level request held through completion is served once
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            armed0 <= 1'b1;
            armed1 <= 1'b1;
        end else begin
            if (!c0_rd && !c0_wr) begin
                armed0 <= 1'b1;
            end else if (c0_done) begin
                armed0 <= 1'b0;
            end
            if (!c1_rd && !c1_wr) begin
                armed1 <= 1'b1;
            end else if (c1_done) begin
                armed1 <= 1'b0;
            end
        end
    end

    // Transaction sequencer with registered host-side and completion outputs
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_lba     <= 32'h0;
            c0_done    <= 1'b0;
            c1_done    <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            tmo_cnt    <= 24'd0;
            c0_err_q   <= 1'b0;
            c1_err_q   <= 1'b0;
`endif
        end else begin
            c0_done <= 1'b0;
            c1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant  <= win;
                        sd_lba <= win_lba;
                        sd_rd  <= win_rd;
                        sd_wr  <= ~win_rd;
                        state  <= ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                        tmo_cnt <= TIMEOUT_CYCLES - 24'd1;
                        if (win) begin
                            c1_err_q <= 1'b0;
                        end else begin
                            c0_err_q <= 1'b0;
                        end
`endif
                    end
                end
                ISSUE: begin
                    // only a fresh synchronized rise counts; an ack already
                    // high on entry has no edge and is ignored
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
`ifdef SD_ARB_TIMEOUT_EN
                    end else if (tmo_cnt == 24'd0) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        c0_done <= ~grant;
                        c1_done <= grant;
                        if (grant) begin
                            c1_err_q <= 1'b1;
                        end else begin
                            c0_err_q <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 24'd1;
`endif
                    end
                end
                XFER: begin
                    // once acked, completion is awaited without a time limit
                    if (ack_fall) begin
                        c0_done <= ~grant;
                        c1_done <= grant;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= grant;
                    sd_lba     <= 32'h0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    assign c0_err = c0_err_q;
    assign c1_err = c1_err_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign c0_err = 1'b0;
    assign c1_err = 1'b0;
`endif

    // grant only moves in IDLE, so this gating is stable across a transfer
    assign busy       = (state != IDLE);
    assign xfer_phase = (state == ISSUE) || (state == XFER);

    assign c0_dout_strobe = sd_dout_strobe & ~grant & xfer_phase;
    assign c1_dout_strobe = sd_dout_strobe &  grant & xfer_phase;
    assign c0_din_strobe  = sd_din_strobe  & ~grant & xfer_phase;
    assign c1_din_strobe  = sd_din_strobe  &  grant & xfer_phase;

    assign c0_ack = ack_sync & ~grant & busy;
    assign c1_ack = ack_sync &  grant & busy;

    assign sd_din = busy ? (grant ? c1_din : c0_din) : 8'h00;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter
// Directed bench for sd_block_arbiter with a cycle-level behavioural model.
// Build with SD_ARB_TIMEOUT_EN defined to exercise the watchdog scenario.
`timescale 1ns/1ps
module tb_sd_block_arbiter;

    localparam logic [23:0] TMO = 24'd100;
`ifdef SD_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk_ram = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] c0_lba = 32'h0, c1_lba = 32'h0;
    logic        c0_rd = 1'b0, c1_rd = 1'b0, c0_wr = 1'b0, c1_wr = 1'b0;
    logic [7:0]  c0_din = 8'h0, c1_din = 8'h0;
    logic        c0_ack, c1_ack, c0_done, c1_done, c0_err, c1_err;
    logic        c0_dout_strobe, c1_dout_strobe, c0_din_strobe, c1_din_strobe;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0, sd_dout_strobe = 1'b0, sd_din_strobe = 1'b0;
    logic [7:0]  sd_din;
    logic        busy, grant;

    sd_block_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_ram(clk_ram), .reset(reset),
        .c0_lba(c0_lba), .c1_lba(c1_lba),
        .c0_rd(c0_rd), .c1_rd(c1_rd), .c0_wr(c0_wr), .c1_wr(c1_wr),
        .c0_din(c0_din), .c1_din(c1_din),
        .c0_ack(c0_ack), .c1_ack(c1_ack),
        .c0_done(c0_done), .c1_done(c1_done),
        .c0_err(c0_err), .c1_err(c1_err),
        .c0_dout_strobe(c0_dout_strobe), .c1_dout_strobe(c1_dout_strobe),
        .c0_din_strobe(c0_din_strobe), .c1_din_strobe(c1_din_strobe),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_dout_strobe(sd_dout_strobe), .sd_din_strobe(sd_din_strobe),
        .sd_din(sd_din), .busy(busy), .grant(grant)
    );

    always #5 clk_ram = ~clk_ram;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 request outstanding, 2 host acked, 3 completion cycle
    int          m_phase = 0, m_grant = 0, m_last = 1, m_nissue = 0;
    logic [31:0] m_lba = 32'h0;
    bit          m_rd = 0, m_wr = 0, m_done0 = 0, m_done1 = 0, m_err0 = 0, m_err1 = 0;
    bit          m_arm0 = 1, m_arm1 = 1;
    bit          s1 = 0, s2 = 0, s3 = 0;   // sd_ack sampled 1, 2, 3 edges ago

    initial begin
        bit r0, r1, od0, od1, rise, fall;
        int w;
        forever begin
            @(posedge clk_ram or posedge reset);
            if (reset) begin
                m_phase = 0; m_grant = 0; m_last = 1; m_nissue = 0; m_lba = 32'h0;
                m_rd = 0; m_wr = 0; m_done0 = 0; m_done1 = 0; m_err0 = 0; m_err1 = 0;
                m_arm0 = 1; m_arm1 = 1; s1 = 0; s2 = 0; s3 = 0;
            end else begin
                od0 = m_done0; od1 = m_done1;
                // the sequencer sees sd_ack two edges late, edge-compared against three
                rise = s2 && !s3;
                fall = !s2 && s3;
                m_done0 = 0; m_done1 = 0;
                r0 = (c0_rd || c0_wr) && m_arm0;
                r1 = (c1_rd || c1_wr) && m_arm1;
                case (m_phase)
                    0: if (r0 || r1) begin
                        if (r0 && r1) w = 1 - m_last;
                        else          w = r1 ? 1 : 0;
                        m_grant  = w;
                        m_lba    = (w == 1) ? c1_lba : c0_lba;
                        m_rd     = (w == 1) ? c1_rd : c0_rd;
                        m_wr     = !m_rd;
                        m_nissue = 0;
                        if (w == 1) m_err1 = 0; else m_err0 = 0;
                        m_phase  = 1;
                    end
                    1: begin
                        m_nissue++;
                        if (rise) begin
                            m_rd = 0; m_wr = 0; m_phase = 2;
                        end else if (TMO_ON && m_nissue == int'(TMO)) begin
                            m_rd = 0; m_wr = 0; m_phase = 3;
                            if (m_grant == 1) begin m_done1 = 1; m_err1 = 1; end
                            else              begin m_done0 = 1; m_err0 = 1; end
                        end
                    end
                    2: if (fall) begin
                        if (m_grant == 1) m_done1 = 1; else m_done0 = 1;
                        m_phase = 3;
                    end
                    default: begin
                        m_last = m_grant; m_lba = 32'h0; m_phase = 0;
                    end
                endcase
                if (!c0_rd && !c0_wr) m_arm0 = 1; else if (od0) m_arm0 = 0;
                if (!c1_rd && !c1_wr) m_arm1 = 1; else if (od1) m_arm1 = 0;
                s3 = s2; s2 = s1; s1 = sd_ack;
            end
        end
    end

    // ---------------- per-cycle compare + event counters ----------------
    int cnt_done0 = 0, cnt_done1 = 0, cnt_c0din = 0, cnt_c1din = 0;
    int cnt_c0dout = 0, cnt_c1dout = 0, busy_cyc = 0, n_glog = 0;
    int glog [0:63];

    initial begin
        bit act;
        logic [7:0] e_din;
        forever begin
            @(negedge clk_ram);
            if (!reset && chk_en) begin
                act   = (m_phase == 1) || (m_phase == 2);
                e_din = (m_phase == 0) ? 8'h00 : ((m_grant == 1) ? c1_din : c0_din);
                check("busy",   busy,   m_phase != 0);
                check("grant",  grant,  m_grant);
                check("sd_rd",  sd_rd,  m_rd);
                check("sd_wr",  sd_wr,  m_wr);
                check("sd_lba", sd_lba, m_lba);
                check("c0_done", c0_done, m_done0);
                check("c1_done", c1_done, m_done1);
                check("c0_err", c0_err, m_err0);
                check("c1_err", c1_err, m_err1);
                check("c0_ack", c0_ack, s2 && m_grant == 0 && m_phase != 0);
                check("c1_ack", c1_ack, s2 && m_grant == 1 && m_phase != 0);
                check("c0_dout_strobe", c0_dout_strobe, sd_dout_strobe && act && m_grant == 0);
                check("c1_dout_strobe", c1_dout_strobe, sd_dout_strobe && act && m_grant == 1);
                check("c0_din_strobe",  c0_din_strobe,  sd_din_strobe && act && m_grant == 0);
                check("c1_din_strobe",  c1_din_strobe,  sd_din_strobe && act && m_grant == 1);
                check("sd_din", sd_din, e_din);
                if (c0_done) cnt_done0++;
                if (c1_done) cnt_done1++;
                if ((c0_done || c1_done) && n_glog < 64) begin
                    glog[n_glog] = int'(grant);
                    n_glog++;
                end
                if (c0_din_strobe)  cnt_c0din++;
                if (c1_din_strobe)  cnt_c1din++;
                if (c0_dout_strobe) cnt_c0dout++;
                if (c1_dout_strobe) cnt_c1dout++;
                if (busy) busy_cyc++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        c0_rd = 0; c0_wr = 0; c1_rd = 0; c1_wr = 0;
        sd_ack = 0; sd_dout_strobe = 0; sd_din_strobe = 0;
        cycles(3);
        reset = 1'b0;
        tick();
    endtask

    // Host side of one sector: wait for a request, ack after dly cycles,
    // issue nstb byte strobes, keep ack high hold more cycles, then release.
    task automatic host_serve(input int dly, input int hold, input int nstb,
                              input bit din_side, input int cl,
                              output int rise_lat, output bit was_wr);
        int n;
        logic [7:0] pat, expd;
        n = 0;
        while (!(sd_rd || sd_wr) && n < 64) begin tick(); n++; end
        check("host_request_seen", sd_rd | sd_wr, 1);
        was_wr = sd_wr;
        cycles(dly);
        sd_ack = 1'b1;
        n = 0;
        while ((sd_rd || sd_wr) && n < 64) begin tick(); n++; end
        rise_lat = n;
        for (int i = 0; i < nstb; i++) begin
            if (din_side) begin
                pat    = 8'(i * 7 + 3);
                c0_din = pat;
                c1_din = ~pat;
                sd_din_strobe = 1'b1;
                expd   = (cl == 1) ? ~pat : pat;
                #1 check("sd_din_at_strobe", sd_din, expd);
            end else begin
                sd_dout_strobe = 1'b1;
            end
            tick();
            sd_din_strobe = 1'b0;
            sd_dout_strobe = 1'b0;
            tick();
        end
        cycles(hold);
        sd_ack = 1'b0;
        n = 0;
        while (!(c0_done || c1_done) && n < 16) begin tick(); n++; end
        check("host_done_seen", c0_done | c1_done, 1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "bench timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int lat, d0, d1, s0, s1c, b0, g0;
        bit wr;
        int exp_g [0:3];
        bit exp_w [0:3];
        bit got_w [0:3];
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
        exp_w[0] = 0; exp_w[1] = 1; exp_w[2] = 0; exp_w[3] = 1;

        // reset values
        #2;
        check("rst_sd_rd", sd_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_sd_lba", sd_lba, 0);
        check("rst_grant", grant, 0);
        do_reset();
        chk_en = 1'b1;

        // single c0 read
        d0 = cnt_done0; s0 = cnt_c1din + cnt_c1dout; s1c = cnt_c0dout;
        c0_lba = 32'h0000_1234; c0_rd = 1'b1;
        tick();
        check("t1_sd_rd_latency", sd_rd, 1);
        check("t1_sd_lba", sd_lba, 32'h0000_1234);
        host_serve(5, 600, 8, 1'b0, 0, lat, wr);
        c0_rd = 1'b0;
        cycles(3);
        check("t1_rd_drop_latency", lat, 3);
        check("t1_done_pulses", cnt_done0 - d0, 1);
        check("t1_c1_strobes", cnt_c1din + cnt_c1dout - s0, 0);
        check("t1_c0_dout_strobes", cnt_c0dout - s1c, 8);

        // two clients, strict alternation
        do_reset();
        g0 = n_glog;
        c0_lba = 32'h100; c1_lba = 32'h200;
        c0_rd = 1'b1; c1_wr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            host_serve(2, 3, 0, 1'b0, k % 2, lat, wr);
            got_w[k] = wr;
            if (k % 2 == 0) begin c0_rd = 1'b0; tick(); c0_rd = 1'b1; end
            else            begin c1_wr = 1'b0; tick(); c1_wr = 1'b1; end
        end
        c0_rd = 1'b0; c1_wr = 1'b0;
        cycles(3);
        check("t2_grant_count", n_glog - g0, 4);
        for (int k = 0; k < 4; k++) begin
            check("t2_grant_seq", glog[g0 + k], exp_g[k]);
            check("t2_sd_wr_dir", got_w[k], exp_w[k]);
        end

        // c1 write with 512 data bytes
        do_reset();
        s0 = cnt_c0din; s1c = cnt_c1din;
        c1_lba = 32'h0000_0777; c1_wr = 1'b1;
        host_serve(2, 4, 512, 1'b1, 1, lat, wr);
        c1_wr = 1'b0;
        cycles(2);
        check("t3_c1_din_strobes", cnt_c1din - s1c, 512);
        check("t3_c0_din_strobes", cnt_c0din - s0, 0);
        check("t3_dir_write", wr, 1);

        // rd and wr together -> read; held request served once
        do_reset();
        d0 = cnt_done0;
        c0_lba = 32'h42; c0_rd = 1'b1; c0_wr = 1'b1;
        tick();
        check("t4_sd_rd", sd_rd, 1);
        check("t4_sd_wr", sd_wr, 0);
        host_serve(1, 2, 0, 1'b0, 0, lat, wr);
        b0 = busy_cyc;
        cycles(20);
        check("t4_no_reserve", busy_cyc - b0, 0);
        c0_rd = 1'b0; c0_wr = 1'b0;
        tick();
        c0_rd = 1'b1;
        host_serve(1, 2, 0, 1'b0, 0, lat, wr);
        c0_rd = 1'b0;
        cycles(2);
        check("t4_two_done", cnt_done0 - d0, 2);

        // watchdog
        do_reset();
        c0_lba = 32'h9; c0_rd = 1'b1;
        tick();
`ifdef SD_ARB_TIMEOUT_EN
        lat = 0;
        while (sd_rd && lat < 200) begin tick(); lat++; end
        check("t5_timeout_cycles", lat, 100);
        check("t5_done", c0_done, 1);
        check("t5_err", c0_err, 1);
        c0_rd = 1'b0;
        cycles(3);
        check("t5_err_sticky", c0_err, 1);
        c0_rd = 1'b1;
        tick();
        check("t5_err_cleared_on_grant", c0_err, 0);
        host_serve(1, 2, 0, 1'b0, 0, lat, wr);
        c0_rd = 1'b0;
        cycles(2);
`else
        cycles(150);
        check("t5_issue_waits", sd_rd, 1);
        check("t5_busy", busy, 1);
        check("t5_err_tied", c0_err, 0);
`endif

        // reset during XFER, then stale ack, then normal c1 grant
        do_reset();
        c0_lba = 32'hABCD; c0_rd = 1'b1;
        tick();
        check("t6_sd_rd", sd_rd, 1);
        sd_ack = 1'b1;
        lat = 0;
        while (sd_rd && lat < 16) begin tick(); lat++; end
        check("t6_in_xfer", lat, 3);
        cycles(2);
        d1 = cnt_done0 + cnt_done1;
        #2 reset = 1'b1;
        #1;
        check("t6_rst_sd_rd", sd_rd, 0);
        check("t6_rst_sd_wr", sd_wr, 0);
        check("t6_rst_busy", busy, 0);
        c0_rd = 1'b0;
        sd_ack = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(3);
        check("t6_no_done", cnt_done0 + cnt_done1 - d1, 0);
        sd_ack = 1'b1;
        cycles(4);
        c1_lba = 32'h55; c1_rd = 1'b1;
        cycles(10);
        check("t6_stale_ack_ignored", sd_rd, 1);
        check("t6_c1_lba", sd_lba, 32'h55);
        sd_ack = 1'b0;
        host_serve(3, 4, 4, 1'b0, 1, lat, wr);
        c1_rd = 1'b0;
        cycles(3);
        check("t6_rd_drop_latency", lat, 3);
        check("t6_c1_granted", glog[n_glog - 1], 1);

        cycles(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
